// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling-free UART receiver sampling mid-bit with a CLK_DIV period
// counter, optional parity, 1 or 2 stop bits and a valid/ready holding register.
module uart_rx_param #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int             CW        = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  HALF_M1   = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1   = CW'(CLK_DIV - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic           ODD_BIT   = (PARITY_ODD != 0);

    if (CLK_DIV < 4 || CLK_DIV > 2047) begin : g_bad_div
        $error("uart_rx_param: CLK_DIV must be within 4..2047");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
        $error("uart_rx_param: DATA_BITS must be within 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 stop_bad;
    logic                 at_half;
    logic                 at_full;

    assign at_half = (cnt == HALF_M1);
    assign at_full = (cnt == FULL_M1);

    // RX is asynchronous to clk; both flops idle high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    // The handshake defaults are written first so a frame completing on the same edge
    // overrides them: overrun then reflects only whether the held frame was lost.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        stop_bad <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START: begin
                    if (at_half) begin
                        cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (at_full) begin
                        cnt   <= '0;
                        shift <= {rxs, shift[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PARITY: begin
                    if (at_full) begin
                        cnt     <= '0;
                        par_bad <= ((^shift) ^ rxs) != ODD_BIT;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (at_full) begin
                        cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            rx_data    <= shift;
                            frame_err  <= stop_bad | ~rxs;
                            parity_err <= (PARITY_EN != 0) ? par_bad : 1'b0;
                            rx_valid   <= 1'b1;
                            overrun    <= rx_valid & ~rx_ready;
                            bit_cnt    <= '0;
                            stop_bad   <= 1'b0;
                            if (rxs) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= WAIT_HIGH;
                            end
                        end else begin
                            stop_bad <= stop_bad | ~rxs;
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
